mc_control_unit: RTL and testbench

- Multi-cycle sequenced control unit for the accumulator CPU; next generation of the combinational opcode decoder.
- Sequences fetch, decode, execute, memory and writeback via an FSM, with req/ack handshakes to instruction and data memory and start/done to the ALU.
- Evaluates branch conditions from the Z/N/C/V flags.
- Traps illegal opcodes.

---
 rtl/mc_cu_pkg.sv | 64 ++++++
 rtl/mc_control_unit_if.sv | 37 +++
 rtl/mc_cu_decode.sv | 49 ++++
 rtl/mc_control_unit.sv | 146 ++++++++++++++
 tb/tb_mc_control_unit.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_cu_pkg.sv
// Shared definitions for the multi-cycle control unit:
// opcode map, FSM state encoding, flag bit indices and decode class bundle.
package mc_cu_pkg;

    localparam logic [5:0] OP_BRZ   = 6'h00;
    localparam logic [5:0] OP_BRN   = 6'h01;
    localparam logic [5:0] OP_BRC   = 6'h02;
    localparam logic [5:0] OP_BRO   = 6'h03;
    localparam logic [5:0] OP_LOAD  = 6'h04;
    localparam logic [5:0] OP_STORE = 6'h05;
    localparam logic [5:0] OP_BRA   = 6'h06;
    localparam logic [5:0] OP_JMP   = 6'h07;
    localparam logic [5:0] OP_RET   = 6'h08;
    localparam logic [5:0] OP_ADD   = 6'h09;
    localparam logic [5:0] OP_SUB   = 6'h0A;
    localparam logic [5:0] OP_ADC   = 6'h0B;
    localparam logic [5:0] OP_SBC   = 6'h0C;
    localparam logic [5:0] OP_LSL   = 6'h0D;
    localparam logic [5:0] OP_RSL   = 6'h0E;
    localparam logic [5:0] OP_MOV   = 6'h0F;
    localparam logic [5:0] OP_MUL   = 6'h10;
    localparam logic [5:0] OP_DIV   = 6'h11;
    localparam logic [5:0] OP_MOD   = 6'h12;
    localparam logic [5:0] OP_AND   = 6'h13;
    localparam logic [5:0] OP_OR    = 6'h14;
    localparam logic [5:0] OP_XOR   = 6'h15;
    localparam logic [5:0] OP_NOT   = 6'h16;
    localparam logic [5:0] OP_CMP   = 6'h17;
    localparam logic [5:0] OP_TST   = 6'h18;
    localparam logic [5:0] OP_INC   = 6'h19;
    localparam logic [5:0] OP_DEC   = 6'h1A;
    localparam logic [5:0] OP_LAST  = 6'h1A;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_ALU_WAIT = 3'd3,
        S_MEM      = 3'd4,
        S_WB       = 3'd5,
        S_TRAP     = 3'd6
    } state_t;

    // is_branch covers the unconditional transfers (bra/jmp/ret);
    // conditional branches are flagged separately by is_cond.
    typedef struct packed {
        logic is_cond;
        logic is_branch;
        logic is_jmp;
        logic is_ret;
        logic is_mov;
        logic is_mem;
        logic is_store;
        logic is_alu;
        logic writes_acc;
        logic is_illegal;
    } dec_t;

endpackage

// File: rtl/mc_control_unit_if.sv
// Handshake/bus bundle between the control unit and the datapath/memories.
// master: control unit side; slave: datapath, memories and ALU side.
interface mc_control_unit_if #(
    parameter int OPC_W = 6
);
    logic             imem_req;
    logic             imem_ack;
    logic [OPC_W-1:0] opcode;
    logic [3:0]       flags;
    logic             alu_start;
    logic             alu_done;
    logic [OPC_W-1:0] alu_op;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ack;
    logic             acc_we;
    logic             flags_we;
    logic             pc_inc;
    logic             pc_load;
    logic             sp_push;
    logic             sp_pop;
    logic             illegal;

    modport master (
        output imem_req, alu_start, alu_op, dmem_req, dmem_we,
        output acc_we, flags_we, pc_inc, pc_load, sp_push, sp_pop,
        output illegal,
        input  imem_ack, opcode, flags, alu_done, dmem_ack
    );

    modport slave (
        input  imem_req, alu_start, alu_op, dmem_req, dmem_we,
        input  acc_we, flags_we, pc_inc, pc_load, sp_push, sp_pop,
        input  illegal,
        output imem_ack, opcode, flags, alu_done, dmem_ack
    );
endinterface

// File: rtl/mc_cu_decode.sv
// Combinational opcode classifier for the control unit.
// Ports: ir (latched opcode) in; cls (dec_t class bundle) out.
module mc_cu_decode
    import mc_cu_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic [OPC_W-1:0] ir,
    output dec_t             cls
);
    logic [5:0] lo;

    always_comb begin
        cls = '0;
        lo  = ir[5:0];
        if (ir > OPC_W'(OP_LAST)) begin
            cls.is_illegal = 1'b1;
        end else begin
            unique case (1'b1)
                (lo <= OP_BRO): cls.is_cond = 1'b1;
                (lo == OP_LOAD): begin
                    cls.is_mem     = 1'b1;
                    cls.writes_acc = 1'b1;
                end
                (lo == OP_STORE): begin
                    cls.is_mem   = 1'b1;
                    cls.is_store = 1'b1;
                end
                (lo == OP_BRA): cls.is_branch = 1'b1;
                (lo == OP_JMP): begin
                    cls.is_branch = 1'b1;
                    cls.is_jmp    = 1'b1;
                end
                (lo == OP_RET): begin
                    cls.is_branch = 1'b1;
                    cls.is_ret    = 1'b1;
                end
                (lo == OP_MOV): begin
                    cls.is_mov     = 1'b1;
                    cls.writes_acc = 1'b1;
                end
                default: begin
                    cls.is_alu     = 1'b1;
                    cls.writes_acc = !(lo == OP_CMP || lo == OP_TST);
                end
            endcase
        end
    end
endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: fetch/decode/exec/mem/wb sequencing with
// req/ack handshakes, branch evaluation from flags and illegal-op trap.
// Ports: clk, rst (async, active-high), bus (mc_control_unit_if.master).
// Optional: MC_CU_MEM_TIMEOUT_EN traps a data access that waits
// TIMEOUT_CYC cycles without dmem_ack.
module mc_control_unit
    import mc_cu_pkg::*;
#(
    parameter int OPC_W       = 6,
    parameter int TIMEOUT_CYC = 255
) (
    input logic                clk,
    input logic                rst,
    mc_control_unit_if.master  bus
);
    state_t           state;
    state_t           state_nx;
    logic [OPC_W-1:0] ir;
    dec_t             cls;
    logic             taken;
    logic             mem_to;

    logic imem_req, alu_start, dmem_req, dmem_we, acc_we, flags_we;
    logic pc_inc, pc_load, sp_push, sp_pop, illegal;

    mc_cu_decode #(.OPC_W(OPC_W)) u_dec (
        .ir  (ir),
        .cls (cls)
    );

    // brz/brn/brc/bro occupy 0..3 in the same order as Z/N/C/V.
    assign taken = bus.flags[ir[1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            ir    <= '0;
        end else begin
            state <= state_nx;
            if (state == S_FETCH && bus.imem_ack)
                ir <= bus.opcode;
        end
    end

`ifdef MC_CU_MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;

    // Held at zero outside MEM, so every MEM visit starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt <= '0;
        else if (state != S_MEM)
            to_cnt <= '0;
        else if (!bus.dmem_ack)
            to_cnt <= to_cnt + 1'b1;
    end

    assign mem_to = (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
    assign mem_to = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        imem_req  = 1'b0;
        alu_start = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        acc_we    = 1'b0;
        flags_we  = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        sp_push   = 1'b0;
        sp_pop    = 1'b0;
        illegal   = 1'b0;
        if (!rst) begin
            unique case (state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (bus.imem_ack)
                        state_nx = S_DECODE;
                end
                S_DECODE: begin
                    state_nx = S_FETCH;
                    unique case (1'b1)
                        cls.is_illegal: state_nx = S_TRAP;
                        cls.is_cond: begin
                            pc_load = taken;
                            pc_inc  = !taken;
                        end
                        cls.is_branch: begin
                            pc_load = 1'b1;
                            sp_push = cls.is_jmp;
                            sp_pop  = cls.is_ret;
                        end
                        cls.is_mov: begin
                            acc_we = 1'b1;
                            pc_inc = 1'b1;
                        end
                        cls.is_mem: state_nx = S_MEM;
                        cls.is_alu: state_nx = S_EXEC;
                        default:    state_nx = S_FETCH;
                    endcase
                end
                S_EXEC: begin
                    alu_start = 1'b1;
                    state_nx  = S_ALU_WAIT;
                end
                S_ALU_WAIT: begin
                    if (bus.alu_done)
                        state_nx = S_WB;
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = cls.is_store;
                    if (bus.dmem_ack)
                        state_nx = S_WB;
                    else if (mem_to)
                        state_nx = S_TRAP;
                end
                S_WB: begin
                    pc_inc   = 1'b1;
                    flags_we = cls.is_alu;
                    acc_we   = cls.writes_acc;
                    state_nx = S_FETCH;
                end
                S_TRAP: illegal = 1'b1;
                default: state_nx = S_FETCH;
            endcase
        end
    end

    assign bus.imem_req  = imem_req;
    assign bus.alu_start = alu_start;
    assign bus.alu_op    = rst ? '0 : ir;
    assign bus.dmem_req  = dmem_req;
    assign bus.dmem_we   = dmem_we;
    assign bus.acc_we    = acc_we;
    assign bus.flags_we  = flags_we;
    assign bus.pc_inc    = pc_inc;
    assign bus.pc_load   = pc_load;
    assign bus.sp_push   = sp_push;
    assign bus.sp_pop    = sp_pop;
    assign bus.illegal   = illegal;
endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: directed scenarios plus
// randomized instruction streams against an instruction-level model.
module tb_mc_control_unit;
    import mc_cu_pkg::*;

`ifdef MC_CU_MEM_TIMEOUT_EN
    localparam int TO   = 4;
    localparam int MAXW = 3;
`else
    localparam int TO   = 255;
    localparam int MAXW = 6;
`endif

    typedef struct {
        int lat, inc, ld, push, pop, acc, flg, start, dreq, dwe;
        int ill, irbad, fbad, dec_inc, dec_ld, wb_acc, wb_flg, wb_inc;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    obs_t ob;

    mc_control_unit_if #(.OPC_W(6)) bus ();

    mc_control_unit #(.OPC_W(6), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] outs();
        return {bus.imem_req, bus.alu_start, bus.dmem_req, bus.dmem_we,
                bus.acc_we, bus.flags_we, bus.pc_inc, bus.pc_load,
                bus.sp_push, bus.sp_pop, bus.illegal};
    endfunction

    task automatic quiet();
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.alu_done = 1'b0;
        bus.opcode   = '0;
        bus.flags    = '0;
    endtask

    // Instruction-level expectations, straight from the opcode semantics.
    function automatic obs_t model(input logic [5:0] op, input logic [3:0] fl,
                                   input int w, input int d);
        obs_t e;
        int   k;
        logic tk;
        e = '{default: 0};
        k = int'(op);
        case (k)
            0: tk = fl[FLG_Z];
            1: tk = fl[FLG_N];
            2: tk = fl[FLG_C];
            default: tk = fl[FLG_V];
        endcase
        if (k <= 3) begin
            e.lat = 2;
            if (tk) e.ld = 1; else e.inc = 1;
        end else if (k == 6 || k == 7 || k == 8) begin
            e.lat  = 2;
            e.ld   = 1;
            e.push = (k == 7) ? 1 : 0;
            e.pop  = (k == 8) ? 1 : 0;
        end else if (k == 15) begin
            e.lat = 2;
            e.acc = 1;
            e.inc = 1;
        end else if (k == 4 || k == 5) begin
            e.lat  = 4 + w;
            e.inc  = 1;
            e.dreq = w + 1;
            e.dwe  = (k == 5) ? w + 1 : 0;
            e.acc  = (k == 4) ? 1 : 0;
        end else begin
            e.lat   = 4 + d;
            e.inc   = 1;
            e.start = 1;
            e.flg   = 1;
            e.acc   = (k == 23 || k == 24) ? 0 : 1;
        end
        return e;
    endfunction

    // Runs one instruction from FETCH and records what the DUT did.
    // Memory acks come after w extra MEM cycles, alu_done d cycles after
    // alu_start; stray acks/done are injected where they must be ignored.
    task automatic run_instr(input logic [5:0] op, input logic [3:0] dfl,
                             input int fw, input int w, input int d);
        int c, mcnt, s;
        bit pend;
        ob = '{default: 0};
        ob.lat = -1;
        for (int i = 0; i < fw; i++) begin
            @(posedge clk); #1;
            bus.imem_ack = 1'b0;
            bus.opcode   = 6'($urandom);
            bus.flags    = 4'($urandom);
            bus.alu_done = 1'($urandom);
            bus.dmem_ack = 1'($urandom);
            @(negedge clk);
            if (!bus.imem_req) ob.fbad++;
        end
        @(posedge clk); #1;
        bus.imem_ack = 1'b1;
        bus.opcode   = op;
        bus.flags    = 4'($urandom);
        bus.alu_done = 1'($urandom);
        bus.dmem_ack = 1'($urandom);
        @(negedge clk);
        if (!bus.imem_req) ob.fbad++;
        c = 0; mcnt = 0; s = 0; pend = 0;
        while (c < 300) begin
            c++;
            @(posedge clk); #1;
            bus.opcode   = 6'($urandom);
            bus.flags    = (c == 1) ? dfl : 4'($urandom);
            bus.imem_ack = bus.imem_req ? 1'b0 : 1'($urandom);
            if (bus.alu_start) begin
                s = c; pend = 1;
                bus.alu_done = 1'($urandom);
            end else if (pend) begin
                bus.alu_done = (c == s + d);
                if (c == s + d) pend = 0;
            end else begin
                bus.alu_done = 1'($urandom);
            end
            if (bus.dmem_req) begin
                mcnt++;
                bus.dmem_ack = (mcnt == w + 1);
            end else begin
                bus.dmem_ack = 1'($urandom);
            end
            @(negedge clk);
            if (bus.imem_req) begin
                ob.lat = c;
                break;
            end
            if (bus.pc_inc)                  ob.inc++;
            if (bus.pc_load)                 ob.ld++;
            if (bus.sp_push)                 ob.push++;
            if (bus.sp_pop)                  ob.pop++;
            if (bus.acc_we)                  ob.acc++;
            if (bus.flags_we)                ob.flg++;
            if (bus.alu_start)               ob.start++;
            if (bus.dmem_req)                ob.dreq++;
            if (bus.dmem_req && bus.dmem_we) ob.dwe++;
            if (bus.illegal)                 ob.ill++;
            if (bus.alu_op !== op)           ob.irbad++;
            if (c == 1) begin
                ob.dec_inc = int'(bus.pc_inc);
                ob.dec_ld  = int'(bus.pc_load);
            end
            ob.wb_acc = int'(bus.acc_we);
            ob.wb_flg = int'(bus.flags_we);
            ob.wb_inc = int'(bus.pc_inc);
        end
        quiet();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        quiet();
        bus.imem_ack = 1'b1;
        bus.dmem_ack = 1'b1;
        bus.alu_done = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (outs() !== 11'd0 || bus.alu_op !== 6'd0) begin
                n_bad++;
                $display("FAIL reset_outs: got %b op %h, want 0", outs(), bus.alu_op);
            end
        end
        @(posedge clk); #1;
        quiet();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (outs() !== 11'b100_0000_0000) begin
            n_bad++;
            $display("FAIL reset_release: got %b, want imem_req only", outs());
        end
    endtask

    task automatic test_branch();
        run_instr(OP_BRZ, 4'b0001, 0, 0, 1);
        n_cmp++;
        if (ob.dec_ld !== 1 || ob.dec_inc !== 0 || ob.lat !== 2) begin
            n_bad++;
            $display("FAIL brz_taken: ld %0d inc %0d lat %0d, want 1 0 2",
                     ob.dec_ld, ob.dec_inc, ob.lat);
        end
        run_instr(OP_BRZ, 4'b0000, 1, 0, 1);
        n_cmp++;
        if (ob.dec_ld !== 0 || ob.dec_inc !== 1 || ob.lat !== 2) begin
            n_bad++;
            $display("FAIL brz_not_taken: ld %0d inc %0d lat %0d, want 0 1 2",
                     ob.dec_ld, ob.dec_inc, ob.lat);
        end
    endtask

    task automatic test_alu();
        run_instr(OP_ADD, 4'($urandom), 0, 0, 3);
        n_cmp++;
        if (ob.start !== 1 || ob.lat !== 7) begin
            n_bad++;
            $display("FAIL add_seq: start %0d lat %0d, want 1 7", ob.start, ob.lat);
        end
        n_cmp++;
        if (ob.wb_acc !== 1 || ob.wb_flg !== 1 || ob.wb_inc !== 1) begin
            n_bad++;
            $display("FAIL add_wb: acc %0d flg %0d inc %0d, want 1 1 1",
                     ob.wb_acc, ob.wb_flg, ob.wb_inc);
        end
        run_instr(OP_CMP, 4'($urandom), 0, 0, 1);
        n_cmp++;
        if (ob.wb_acc !== 0 || ob.wb_flg !== 1 || ob.lat !== 5) begin
            n_bad++;
            $display("FAIL cmp_wb: acc %0d flg %0d lat %0d, want 0 1 5",
                     ob.wb_acc, ob.wb_flg, ob.lat);
        end
    endtask

    task automatic test_mem();
        run_instr(OP_LOAD, 4'($urandom), 0, 3, 1);
        n_cmp++;
        if (ob.dreq !== 4 || ob.dwe !== 0 || ob.wb_acc !== 1 || ob.lat !== 7) begin
            n_bad++;
            $display("FAIL load: req %0d we %0d acc %0d lat %0d, want 4 0 1 7",
                     ob.dreq, ob.dwe, ob.wb_acc, ob.lat);
        end
        run_instr(OP_STORE, 4'($urandom), 0, 3, 1);
        n_cmp++;
        if (ob.dreq !== 4 || ob.dwe !== 4 || ob.acc !== 0 || ob.ill !== 0) begin
            n_bad++;
            $display("FAIL store: req %0d we %0d acc %0d ill %0d, want 4 4 0 0",
                     ob.dreq, ob.dwe, ob.acc, ob.ill);
        end
`ifndef MC_CU_MEM_TIMEOUT_EN
        run_instr(OP_LOAD, 4'($urandom), 0, 40, 1);
        n_cmp++;
        if (ob.dreq !== 41 || ob.lat !== 44 || ob.ill !== 0) begin
            n_bad++;
            $display("FAIL long_wait: req %0d lat %0d ill %0d, want 41 44 0",
                     ob.dreq, ob.lat, ob.ill);
        end
`endif
    endtask

    task automatic test_reset_mid_mem();
        @(posedge clk); #1;
        quiet();
        bus.imem_ack = 1'b1;
        bus.opcode   = OP_STORE;
        @(posedge clk); #1;
        quiet();
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_mem_pre: req %b we %b, want 1 1", bus.dmem_req, bus.dmem_we);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (outs() !== 11'd0) begin
            n_bad++;
            $display("FAIL mid_mem_rst: got %b, want 0", outs());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (outs() !== 11'b100_0000_0000) begin
            n_bad++;
            $display("FAIL mid_mem_release: got %b, want imem_req only", outs());
        end
    endtask

    task automatic trap_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        quiet();
        #1;
        n_cmp++;
        if (bus.illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL trap_clear: illegal %b, want 0", bus.illegal);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (outs() !== 11'b100_0000_0000) begin
            n_bad++;
            $display("FAIL trap_release: got %b, want imem_req only", outs());
        end
    endtask

    task automatic test_illegal(input logic [5:0] op, input int n);
        int bad;
        @(posedge clk); #1;
        quiet();
        bus.imem_ack = 1'b1;
        bus.opcode   = op;
        @(posedge clk); #1;
        quiet();
        @(negedge clk);
        n_cmp++;
        if (outs() !== 11'd0) begin
            n_bad++;
            $display("FAIL illegal_decode op %h: got %b, want 0", op, outs());
        end
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.imem_ack = 1'($urandom);
            bus.dmem_ack = 1'($urandom);
            bus.alu_done = 1'($urandom);
            bus.opcode   = 6'($urandom);
            bus.flags    = 4'($urandom);
            @(negedge clk);
            if (outs() !== 11'b000_0000_0001) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL trap_hold op %h: %0d bad cycles of %0d, want 0", op, bad, n);
        end
        trap_reset();
    endtask

`ifdef MC_CU_MEM_TIMEOUT_EN
    task automatic test_timeout();
        int reqs;
        @(posedge clk); #1;
        quiet();
        bus.imem_ack = 1'b1;
        bus.opcode   = OP_STORE;
        @(posedge clk); #1;
        quiet();
        reqs = 0;
        for (int i = 0; i < TO; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.dmem_req) reqs++;
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (reqs !== TO || bus.illegal !== 1'b1 || bus.dmem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout: req %0d ill %b dreq %b, want %0d 1 0",
                     reqs, bus.illegal, bus.dmem_req, TO);
        end
        trap_reset();
        run_instr(OP_STORE, 4'($urandom), 0, TO - 1, 1);
        n_cmp++;
        if (ob.ill !== 0 || ob.lat !== 3 + TO || ob.wb_inc !== 1) begin
            n_bad++;
            $display("FAIL ack_wins: ill %0d lat %0d inc %0d, want 0 %0d 1",
                     ob.ill, ob.lat, ob.wb_inc, 3 + TO);
        end
    endtask
`endif

    task automatic test_random(input int n);
        logic [5:0] op;
        logic [3:0] fl;
        int w, d;
        obs_t e;
        for (int i = 0; i < n; i++) begin
            op = 6'($urandom_range(26));
            fl = 4'($urandom);
            w  = $urandom_range(MAXW);
            d  = $urandom_range(4, 1);
            run_instr(op, fl, $urandom_range(2), w, d);
            e = model(op, fl, w, d);
            n_cmp++;
            if (ob.lat !== e.lat) begin
                n_bad++;
                $display("FAIL rnd_lat op %h: got %0d want %0d", op, ob.lat, e.lat);
            end
            n_cmp++;
            if (ob.inc !== e.inc || ob.ld !== e.ld) begin
                n_bad++;
                $display("FAIL rnd_pc op %h fl %b: inc %0d ld %0d want %0d %0d",
                         op, fl, ob.inc, ob.ld, e.inc, e.ld);
            end
            n_cmp++;
            if (ob.push !== e.push || ob.pop !== e.pop) begin
                n_bad++;
                $display("FAIL rnd_sp op %h: push %0d pop %0d want %0d %0d",
                         op, ob.push, ob.pop, e.push, e.pop);
            end
            n_cmp++;
            if (ob.acc !== e.acc || ob.flg !== e.flg) begin
                n_bad++;
                $display("FAIL rnd_wr op %h: acc %0d flg %0d want %0d %0d",
                         op, ob.acc, ob.flg, e.acc, e.flg);
            end
            n_cmp++;
            if (ob.start !== e.start) begin
                n_bad++;
                $display("FAIL rnd_start op %h: got %0d want %0d", op, ob.start, e.start);
            end
            n_cmp++;
            if (ob.dreq !== e.dreq || ob.dwe !== e.dwe) begin
                n_bad++;
                $display("FAIL rnd_dmem op %h: req %0d we %0d want %0d %0d",
                         op, ob.dreq, ob.dwe, e.dreq, e.dwe);
            end
            n_cmp++;
            if (ob.ill !== 0 || ob.irbad !== 0 || ob.fbad !== 0) begin
                n_bad++;
                $display("FAIL rnd_misc op %h: ill %0d ir %0d fetch %0d want 0 0 0",
                         op, ob.ill, ob.irbad, ob.fbad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_alu();
        test_mem();
        test_reset_mid_mem();
        test_illegal(6'h1B, 20);
        test_illegal(6'($urandom_range(63, 28)), 5);
`ifdef MC_CU_MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_random(80);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
